ahblite_microcode_ctrl: RTL and testbench
=========================================

Name: ahblite_microcode_ctrl

Overview:
- AHB-Lite slave on decoder Port5 (0x40000030–0x4000003F); consumes P5_HSEL from the system decoder.
- Holds START/END/CTRL registers and a GPIO input readback.
- Runs a sequencer that fetches 32-bit microcode words from the MicroCode RAM (Port6, 256 words, synchronous read port) and drives a 16-bit GPIO output pattern for a programmed number of cycles per word.

Parameters:
- ADDR_W, 8, microcode RAM word-address width (256 words = 0x400 bytes).
- GPIO_W, 16, GPIO output/input width; must be ≤ 16.

Ports:
- HCLK  input  1  system clock.
- HRESETn  input  1  asynchronous active-low reset.
- HSEL  input  1  slave select from decoder (P5_HSEL).
- HADDR  input  32  AHB address.
- HTRANS  input  2  AHB transfer type.
- HSIZE  input  3  AHB size (ignored; word access only).
- HPROT  input  4  ignored.
- HWRITE  input  1  AHB write.
- HWDATA  input  32  AHB write data.
- HREADY  input  1  bus ready.
- HREADYOUT  output  1  constant 1.
- HRDATA  output  32  read data.
- HRESP  output  1  constant 0 (OKAY).
- ucode_addr  output  ADDR_W  microcode RAM read word address.
- ucode_rdata  input  32  RAM data; valid one cycle after ucode_addr.
- gpio_in  input  GPIO_W  external inputs.
- gpio_out  output  GPIO_W  sequenced output pattern.
- busy  output  1  sequencer not IDLE.
- done  output  1  one-cycle pulse when a non-loop run completes.

Behaviour:
- Reset (HRESETn low, asynchronous): START=0, END=0, EN=0, LOOP=0, pc=0, cnt=0, state=IDLE, gpio_out=0, done=0, ucode_addr=0, HRDATA=0.
- AHB address phase accepted when HSEL & HREADY & HTRANS[1]. Register HADDR[3:2] and HWRITE into a data-phase latch; the latch valid bit clears when no transfer is accepted.
- Writes complete in the data phase using HWDATA. Zero wait states.
- Reads: HRDATA is combinational from the latched offset and returns current values.
- Register map:
  - 0x30 START: bits[7:0] RW.
  - 0x34 END: bits[7:0] RW.
  - 0x38 CTRL: bit0 EN (RW), bit1 LOOP (RW), bit8 BUSY (RO). Other bits read 0.
  - 0x3C GPIO_IN (RO): gpio_in double-flopped, zero-extended. Writes to 0x3C are ignored.
- Microcode word format: [GPIO_W-1:0] output pattern; [31:16] hold count H (unsigned).
- States:
  - IDLE: a CTRL write with EN=1 sets pc←START, then FETCH.
  - FETCH: ucode_addr=pc. Next state LOAD.
  - LOAD: gpio_out←rdata[15:0]; cnt←H. If H==0, go to NEXT; else HOLD.
  - HOLD: cnt decrements each cycle. When cnt reaches 1, go to NEXT.
  - NEXT: if pc==END (live value), then:
    - LOOP=1: pc←START, FETCH.
    - LOOP=0: EN←0, done=1 for one cycle, IDLE.
  - NEXT otherwise: pc←pc+1 (mod 256), FETCH.
- Cycle cost per word: 3 + H (FETCH, LOAD, NEXT, plus H HOLD cycles).
- gpio_out updates on the clock edge ending LOAD; it holds its last value in IDLE and after abort.
- Abort: a CTRL write with EN=0 while busy forces IDLE on the next edge; no done pulse; gpio_out is retained.
- A CTRL write with EN=1 while already busy updates LOOP only; no restart.
- START>END: pc wraps through 0xFF→0x00 until it equals END.
- START/END written mid-run take effect at the next NEXT comparison or loop restart.
- BUSY = (state != IDLE). busy port equals BUSY.
- Simultaneous completion (NEXT, LOOP=0) and a CTRL write in the same cycle: the bus write wins for EN, and done still pulses.
- Reset asserted mid-run: immediate return to reset values.

Test Plan:
- Reset: hold HRESETn low, then release → read 0x30/0x34/0x38 = 0, gpio_out=0, busy=0.
- Register access:
  - Write 0x30=0x05, 0x34=0x07 → reads return 0x05 and 0x07.
  - Drive gpio_in=0xA5A5 → after 2 cycles, 0x3C reads 0x0000A5A5.
  - Write 0x3C → no effect.
- Single run: RAM[5]=0x0002_0011, RAM[6]=0x0000_0022, RAM[7]=0x0001_0033; write CTRL=0x1.
  - Expected gpio_out sequence: 0x11 held 5 cycles, 0x22 for 3 cycles, 0x33 until done.
  - Expected totals: 5+3+4 cycles, one done pulse, CTRL reads 0x0.
- Loop: CTRL=0x3 with the same program → pattern repeats with period 12 cycles, no done pulse.
  - Then write CTRL=0x0 → busy=0 next cycle, gpio_out frozen.
- Wrap: START=0xFE, END=0x01, H=0 everywhere → ucode_addr sequence FE, FF, 00, 01, then done.
- Reset mid-run: assert HRESETn low during HOLD → gpio_out=0 and busy=0 asynchronously; after release, state is IDLE.

Source files
------------

// File: rtl/ahblite_microcode_ctrl.sv
// AHB-Lite register slave plus microcode sequencer.
// The bus side exposes START/END/CTRL and a synchronised GPIO input readback.
// The sequencer walks microcode words START..END. Each word drives a GPIO
// pattern and holds it for a number of cycles given in the word.
module ahblite_microcode_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned GPIO_W = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [3:0]        HPROT,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic [31:0]       HRDATA,
    output logic              HRESP,
    output logic [ADDR_W-1:0] ucode_addr,
    input  logic [31:0]       ucode_rdata,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_HOLD,
        S_NEXT
    } state_t;

    state_t state, state_nxt;

    // Data-phase latch
    logic       dp_valid;
    logic       dp_write;
    logic [1:0] dp_offset;

    // Programmer-visible registers
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              run_en;
    logic              loop_en;
    logic [GPIO_W-1:0] gpio_sync1;
    logic [GPIO_W-1:0] gpio_sync2;

    // Sequencer datapath
    logic [ADDR_W-1:0] pc;
    logic [15:0]       cnt;
    logic [GPIO_W-1:0] gpio_reg;

    // Strobes from the next-state logic
    logic accept;
    logic bus_wr;
    logic ctrl_wr;
    logic pc_load_start;
    logic pc_inc;
    logic load_word;
    logic run_done;

    logic unused_bits;

    assign HREADYOUT  = 1'b1;
    assign HRESP      = 1'b0;
    assign busy       = (state != S_IDLE);
    assign ucode_addr = pc;
    assign gpio_out   = gpio_reg;

    assign accept  = HSEL & HREADY & HTRANS[1];
    assign bus_wr  = dp_valid & dp_write;
    assign ctrl_wr = bus_wr & (dp_offset == 2'd2);

    assign unused_bits = ^{HTRANS[0], HSIZE, HPROT, HADDR[31:4], HADDR[1:0],
                           HWDATA[31:8], ucode_rdata};

    // Capture the address phase; valid drops whenever no transfer is accepted
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_offset <= 2'd0;
        end else begin
            dp_valid <= accept;
            if (accept) begin
                dp_write  <= HWRITE;
                dp_offset <= HADDR[3:2];
            end
        end
    end

    // START/END register writes and GPIO input double-flop
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            start_addr <= '0;
            end_addr   <= '0;
            gpio_sync1 <= '0;
            gpio_sync2 <= '0;
        end else begin
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
            if (bus_wr && dp_offset == 2'd0) begin
                start_addr <= HWDATA[ADDR_W-1:0];
            end
            if (bus_wr && dp_offset == 2'd1) begin
                end_addr <= HWDATA[ADDR_W-1:0];
            end
        end
    end

    // Combinational read mux driven by the latched offset
    always_comb begin
        HRDATA = '0;
        if (dp_valid && !dp_write) begin
            case (dp_offset)
                2'd0:    HRDATA = 32'(start_addr);
                2'd1:    HRDATA = 32'(end_addr);
                2'd2:    HRDATA = {23'd0, busy, 6'd0, loop_en, run_en};
                default: HRDATA = 32'(gpio_sync2);
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencer next-state and datapath strobes
    always_comb begin
        state_nxt     = state;
        pc_load_start = 1'b0;
        pc_inc        = 1'b0;
        load_word     = 1'b0;
        run_done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (ctrl_wr && HWDATA[0]) begin
                    state_nxt     = S_FETCH;
                    pc_load_start = 1'b1;
                end
            end
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD: begin
                load_word = 1'b1;
                state_nxt = (ucode_rdata[31:16] == 16'd0) ? S_NEXT : S_HOLD;
            end
            S_HOLD: begin
                if (cnt == 16'd1) begin
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (pc == end_addr) begin
                    if (loop_en) begin
                        state_nxt     = S_FETCH;
                        pc_load_start = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        run_done  = 1'b1;
                    end
                end else begin
                    state_nxt = S_FETCH;
                    pc_inc    = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Abort overrides the walk; a completion in the same cycle still reports done
        if (state != S_IDLE && ctrl_wr && !HWDATA[0]) begin
            state_nxt     = S_IDLE;
            pc_load_start = 1'b0;
            pc_inc        = 1'b0;
            load_word     = 1'b0;
        end
    end

    // Program counter, hold counter, output pattern, CTRL bits and done pulse
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pc       <= '0;
            cnt      <= '0;
            gpio_reg <= '0;
            run_en   <= 1'b0;
            loop_en  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= run_done;
            if (pc_load_start) begin
                pc <= start_addr;
            end else if (pc_inc) begin
                pc <= pc + ADDR_W'(1);
            end
            if (load_word) begin
                gpio_reg <= ucode_rdata[GPIO_W-1:0];
                cnt      <= ucode_rdata[31:16];
            end else if (state == S_HOLD) begin
                cnt <= cnt - 16'd1;
            end
            if (ctrl_wr) begin
                run_en  <= HWDATA[0];
                loop_en <= HWDATA[1];
            end else if (run_done) begin
                run_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahblite_microcode_ctrl.sv
// Testbench for ahblite_microcode_ctrl: register vectors, directed run/loop/wrap/reset
// sequences and randomized programs checked against a per-word cycle-cost model.
module tb_ahblite_microcode_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic [2:0]  HSIZE = 3'd2;
    logic [3:0]  HPROT = '0;
    logic        HWRITE = 1'b0;
    logic [31:0] HWDATA = '0;
    logic        HREADY = 1'b1;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic [7:0]  ucode_addr;
    logic [31:0] ucode_rdata = '0;
    logic [15:0] gpio_in = '0;
    logic [15:0] gpio_out;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    logic [31:0] ram [256];
    logic [15:0] model_gpio;

    logic [15:0] exp_gpio  [1024];
    bit          exp_busy  [1024];
    bit          exp_done  [1024];
    bit          exp_fetch [1024];
    logic [7:0]  exp_addr  [1024];
    logic [7:0]  fetched_q [$];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [18];

    ahblite_microcode_ctrl #(.ADDR_W(8), .GPIO_W(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP), .ucode_addr(ucode_addr),
        .ucode_rdata(ucode_rdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .busy(busy), .done(done)
    );

    always #5 HCLK = ~HCLK;

    // Synchronous-read microcode RAM
    always @(posedge HCLK) ucode_rdata <= ram[ucode_addr];

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b1;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        tick();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b0;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
        tick();
    endtask

    // Expected per-cycle trace: each word costs 3+H cycles, its pattern becomes
    // visible from its third cycle on; a finished run adds one done cycle and one idle cycle.
    task automatic build_trace(input logic [7:0] st, input logic [7:0] sp, input bit lp,
                               input int max_c, output int n, output logic [15:0] g_end);
        int c;
        int h;
        logic [7:0]  pc;
        logic [15:0] g;
        logic [31:0] w;
        bit fin;
        c = 0; pc = st; g = model_gpio; fin = 1'b0;
        while (!fin && c < max_c) begin
            w = ram[pc];
            h = int'(w[31:16]);
            for (int j = 0; j < 3 + h; j++) begin
                if (j == 2) g = w[15:0];
                if (c < 1024) begin
                    exp_gpio[c] = g; exp_busy[c] = 1'b1; exp_done[c] = 1'b0;
                    exp_fetch[c] = (j == 0); exp_addr[c] = pc;
                end
                c++;
            end
            if (pc == sp) begin
                if (lp) pc = st;
                else    fin = 1'b1;
            end else begin
                pc = pc + 8'd1;
            end
        end
        if (fin) begin
            for (int k = 0; k < 2; k++) begin
                if (c < 1024) begin
                    exp_gpio[c] = g; exp_busy[c] = 1'b0; exp_done[c] = (k == 0);
                    exp_fetch[c] = 1'b0; exp_addr[c] = 8'd0;
                end
                c++;
            end
        end
        n = (c > max_c) ? max_c : c;
        g_end = g;
    endtask

    task automatic apply_trace(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            check($sformatf("%s gpio_out c%0d", tag, c), 32'(gpio_out), 32'(exp_gpio[c]));
            check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(exp_busy[c]));
            check($sformatf("%s done c%0d", tag, c), 32'(done), 32'(exp_done[c]));
            if (exp_fetch[c]) begin
                fetched_q.push_back(ucode_addr);
                check($sformatf("%s ucode_addr c%0d", tag, c), 32'(ucode_addr), 32'(exp_addr[c]));
            end
            tick();
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [15:0] g_end;
        logic [7:0]  wrap_exp [4];
        logic [7:0]  st;
        logic [7:0]  sp;
        int n;
        int len;

        for (int i = 0; i < 256; i++) ram[i] = '0;
        model_gpio = '0;

        // Reset state
        repeat (3) tick();
        HRESETn = 1'b1;
        tick();
        check("reset gpio_out", 32'(gpio_out), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset ucode_addr", 32'(ucode_addr), 32'h0);
        check("reset HRDATA", HRDATA, 32'h0);
        check("HREADYOUT", 32'(HREADYOUT), 32'h1);
        check("HRESP", 32'(HRESP), 32'h0);

        // Register access vectors
        gpio_in = 16'hA5A5;
        tick(); tick();
        vecs[0]  = '{1'b0, 32'h4000_0030, 32'h0};
        vecs[1]  = '{1'b0, 32'h4000_0034, 32'h0};
        vecs[2]  = '{1'b0, 32'h4000_0038, 32'h0};
        vecs[3]  = '{1'b1, 32'h4000_0030, 32'h5};
        vecs[4]  = '{1'b1, 32'h4000_0034, 32'h7};
        vecs[5]  = '{1'b0, 32'h4000_0030, 32'h5};
        vecs[6]  = '{1'b0, 32'h4000_0034, 32'h7};
        vecs[7]  = '{1'b1, 32'h4000_003C, 32'h1234};
        vecs[8]  = '{1'b0, 32'h4000_003C, 32'h0000_A5A5};
        vecs[9]  = '{1'b0, 32'h4000_0030, 32'h5};
        vecs[10] = '{1'b1, 32'h4000_0038, 32'h2};
        vecs[11] = '{1'b0, 32'h4000_0038, 32'h2};
        vecs[12] = '{1'b1, 32'h4000_0038, 32'h0};
        vecs[13] = '{1'b0, 32'h4000_0038, 32'h0};
        vecs[14] = '{1'b1, 32'h4000_0030, 32'h1FF};
        vecs[15] = '{1'b0, 32'h4000_0030, 32'hFF};
        vecs[16] = '{1'b1, 32'h4000_0030, 32'h5};
        vecs[17] = '{1'b0, 32'h4000_0030, 32'h5};
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec%0d read 0x%02h", i, vecs[i].addr[7:0]), rd, vecs[i].data);
            end
        end
        check("idle after register vectors", 32'(busy), 32'h0);

        // Single run: 0x11 for 5 cycles, 0x22 for 3, 0x33 until done
        ram[5] = 32'h0002_0011;
        ram[6] = 32'h0000_0022;
        ram[7] = 32'h0001_0033;
        bus_write(32'h4000_0038, 32'h1);
        build_trace(8'd5, 8'd7, 1'b0, 1000, n, g_end);
        check("single run length", n, 14);
        apply_trace("single", n);
        model_gpio = g_end;
        bus_read(32'h4000_0038, rd);
        check("single CTRL after done", rd, 32'h0);

        // Loop then abort
        bus_write(32'h4000_0038, 32'h3);
        build_trace(8'd5, 8'd7, 1'b1, 38, n, g_end);
        apply_trace("loop", 36);
        bus_write(32'h4000_0038, 32'h0);
        check("abort busy", 32'(busy), 32'h0);
        check("abort gpio frozen", 32'(gpio_out), 32'(exp_gpio[37]));
        repeat (4) tick();
        check("abort gpio later", 32'(gpio_out), 32'(exp_gpio[37]));
        check("abort no done", 32'(done), 32'h0);
        check("abort busy later", 32'(busy), 32'h0);
        model_gpio = exp_gpio[37];
        bus_read(32'h4000_0038, rd);
        check("abort CTRL", rd, 32'h0);

        // Wrap through 0xFF -> 0x00
        ram[8'hFE] = 32'h0000_B0FE;
        ram[8'hFF] = 32'h0000_B0FF;
        ram[8'h00] = 32'h0000_B000;
        ram[8'h01] = 32'h0000_B001;
        bus_write(32'h4000_0030, 32'hFE);
        bus_write(32'h4000_0034, 32'h01);
        bus_write(32'h4000_0038, 32'h1);
        build_trace(8'hFE, 8'h01, 1'b0, 1000, n, g_end);
        fetched_q.delete();
        apply_trace("wrap", n);
        model_gpio = g_end;
        wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;
        check("wrap fetch count", fetched_q.size(), 4);
        for (int i = 0; i < 4 && i < fetched_q.size(); i++) begin
            check($sformatf("wrap fetch %0d", i), 32'(fetched_q[i]), 32'(wrap_exp[i]));
        end

        // Randomized programs, some starting near the wrap point
        for (int r = 0; r < 10; r++) begin
            st  = (r < 3) ? 8'(8'hFC + r) : 8'($urandom_range(0, 255));
            len = $urandom_range(1, 6);
            sp  = st + 8'(len - 1);
            for (int i = 0; i < len; i++) begin
                ram[8'(st + 8'(i))] = {16'($urandom_range(0, 3)), 16'($urandom)};
            end
            bus_write(32'h4000_0030, 32'(st));
            bus_write(32'h4000_0034, 32'(sp));
            bus_write(32'h4000_0038, 32'h1);
            build_trace(st, sp, 1'b0, 1000, n, g_end);
            apply_trace($sformatf("rand%0d", r), n);
            model_gpio = g_end;
        end

        // Reset asserted during HOLD
        ram[5] = 32'h0002_0011;
        ram[6] = 32'h0000_0022;
        ram[7] = 32'h0001_0033;
        bus_write(32'h4000_0030, 32'h5);
        bus_write(32'h4000_0034, 32'h7);
        bus_write(32'h4000_0038, 32'h1);
        repeat (3) tick();
        check("pre-reset gpio", 32'(gpio_out), 32'h11);
        check("pre-reset busy", 32'(busy), 32'h1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("async reset gpio", 32'(gpio_out), 32'h0);
        check("async reset busy", 32'(busy), 32'h0);
        tick(); tick();
        HRESETn = 1'b1;
        repeat (3) tick();
        check("post-reset busy", 32'(busy), 32'h0);
        check("post-reset gpio", 32'(gpio_out), 32'h0);
        bus_read(32'h4000_0030, rd);
        check("post-reset START", rd, 32'h0);
        bus_read(32'h4000_0038, rd);
        check("post-reset CTRL", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
